acoustic_ping_detector: RTL

Receive-side counterpart to the Perseus II 40 kHz burst pinger. Watches one digitized (comparator-squared) hydrophone channel and validates a burst by its period. Reports a time-of-arrival timestamp taken from the first edge of the burst, then reports burst length when the burst ends. One instance per hydrophone feeds the USBL bearing solver, which differences the timestamps across channels.

---
 rtl/acoustic_ping_detector_if.sv | 35 +++
 rtl/acoustic_ping_detector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/acoustic_ping_detector_if.sv
// rtl/acoustic_ping_detector_if.sv - signal bundle between a hydrophone channel and its ping detector
//
// Purpose: groups the detector's per-channel control inputs and result outputs.
// Signals:
//   sig_in       comparator output (asynchronous to clk)
//   enable       arms detection; low forces the detector idle
//   ts_clear     synchronous clear of the timestamp counter
//   toa_valid    one-cycle pulse on lock
//   toa          timestamp of the first edge of the locked burst (held)
//   burst_done   one-cycle pulse when a locked burst ends
//   burst_cycles valid periods in the finished burst, saturating at 255 (held)
//   busy         detector is not idle
// Modports: slave = detector side, master = driver/observer side.
interface acoustic_ping_detector_if #(
  parameter int TS_WIDTH = 32
);
  logic                sig_in;
  logic                enable;
  logic                ts_clear;
  logic                toa_valid;
  logic [TS_WIDTH-1:0] toa;
  logic                burst_done;
  logic [7:0]          burst_cycles;
  logic                busy;

  modport slave (
    input  sig_in, enable, ts_clear,
    output toa_valid, toa, burst_done, burst_cycles, busy
  );

  modport master (
    output sig_in, enable, ts_clear,
    input  toa_valid, toa, burst_done, burst_cycles, busy
  );
endinterface

// File: rtl/acoustic_ping_detector.sv
// rtl/acoustic_ping_detector.sv - period-validated acoustic ping detector with time-of-arrival stamp
//
// Purpose: watches one squared hydrophone channel, locks onto a burst whose
// rising-edge spacing stays within PERIOD_NOM +/- PERIOD_TOL for MIN_CYCLES
// periods, reports the timestamp of the burst's first edge, then reports the
// burst length when it ends, followed by a reverb holdoff.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    acoustic_ping_detector_if.slave (sig_in/enable/ts_clear in,
//          toa_valid/toa/burst_done/burst_cycles/busy out)
// Optional feature macro: PING_GLITCH_FILTER_EN adds a 3-sample majority
// filter after the synchronizer (input latency 5 instead of 3).
module acoustic_ping_detector #(
  parameter int PERIOD_NOM     = 2500,
  parameter int PERIOD_TOL     = 125,
  parameter int MIN_CYCLES     = 8,
  parameter int HOLDOFF_CYCLES = 100000000,
  parameter int TS_WIDTH       = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  acoustic_ping_detector_if.slave  bus
);

  localparam logic [15:0] PER_MIN  = 16'(PERIOD_NOM - PERIOD_TOL);
  localparam logic [15:0] PER_MAX  = 16'(PERIOD_NOM + PERIOD_TOL);
  localparam logic [7:0]  RUN_LOCK = 8'(MIN_CYCLES);
  localparam int          HOLD_W   = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES);
  localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
  localparam logic [TS_WIDTH-1:0] TS_ONE    = TS_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_LOCKED, ST_HOLDOFF} state_t;

  // Input path
  logic r_sync1, r_sync2, r_lvl_d, r_rise;
  logic w_lvl;

`ifdef PING_GLITCH_FILTER_EN
  logic r_h1, r_h2, r_filt;
  logic w_maj;

  assign w_maj = (r_sync2 & r_h1) | (r_sync2 & r_h2) | (r_h1 & r_h2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h1   <= 1'b0;
      r_h2   <= 1'b0;
      r_filt <= 1'b0;
    end else begin
      r_h1   <= r_sync2;
      r_h2   <= r_h1;
      r_filt <= w_maj;
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_sync2;
`endif

  // Rise is registered so the total input latency lands on an exact count
  // (3 unfiltered, 5 filtered) relative to the sig_in transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_lvl_d <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= bus.sig_in;
      r_sync2 <= r_sync1;
      r_lvl_d <= w_lvl;
      r_rise  <= w_lvl & ~r_lvl_d;
    end
  end

  // Timestamp and edge-spacing counters
  logic [TS_WIDTH-1:0] r_ts;
  logic [15:0]         r_per;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts  <= '0;
      r_per <= '0;
    end else begin
      r_ts <= bus.ts_clear ? '0 : r_ts + TS_ONE;
      if (r_rise)
        r_per <= 16'd1;
      else if (r_per != 16'hFFFF)
        r_per <= r_per + 16'd1;
    end
  end

  logic w_valid, w_timeout;
  assign w_valid   = (r_per >= PER_MIN) && (r_per <= PER_MAX);
  assign w_timeout = (r_per > PER_MAX);

  // FSM
  state_t              r_state, w_state_nxt;
  logic [7:0]          r_run, w_run_nxt, w_run_inc;
  logic [TS_WIDTH-1:0] r_cand, w_cand_nxt;
  logic [HOLD_W-1:0]   r_hold, w_hold_nxt;
  logic [TS_WIDTH-1:0] r_toa, w_toa_nxt;
  logic [7:0]          r_cycles, w_cycles_nxt;
  logic                r_toa_valid, w_toa_valid_nxt;
  logic                r_burst_done, w_burst_done_nxt;

  assign w_run_inc = (r_run == 8'hFF) ? r_run : r_run + 8'd1;

  always_comb begin
    w_state_nxt      = r_state;
    w_run_nxt        = r_run;
    w_cand_nxt       = r_cand;
    w_hold_nxt       = r_hold;
    w_toa_nxt        = r_toa;
    w_cycles_nxt     = r_cycles;
    w_toa_valid_nxt  = 1'b0;
    w_burst_done_nxt = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_rise) begin
            w_cand_nxt  = r_ts;
            w_run_nxt   = 8'd0;
            w_state_nxt = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (r_rise) begin
            if (w_valid) begin
              w_run_nxt = w_run_inc;
              if (w_run_inc == RUN_LOCK) begin
                w_toa_nxt       = r_cand;
                w_toa_valid_nxt = 1'b1;
                w_state_nxt     = ST_LOCKED;
              end
            end else begin
              // This edge becomes the new candidate start of a burst.
              w_cand_nxt = r_ts;
              w_run_nxt  = 8'd0;
            end
          end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if ((r_rise && !w_valid) || (!r_rise && w_timeout)) begin
            w_cycles_nxt     = r_run;
            w_burst_done_nxt = 1'b1;
            w_hold_nxt       = HOLD_LOAD;
            w_state_nxt      = ST_HOLDOFF;
          end else if (r_rise) begin
            w_run_nxt = w_run_inc;
          end
        end
        ST_HOLDOFF: begin
          if (r_hold == '0)
            w_state_nxt = ST_IDLE;
          else
            w_hold_nxt = r_hold - HOLD_ONE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_run        <= '0;
      r_cand       <= '0;
      r_hold       <= '0;
      r_toa        <= '0;
      r_cycles     <= '0;
      r_toa_valid  <= 1'b0;
      r_burst_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_run        <= w_run_nxt;
      r_cand       <= w_cand_nxt;
      r_hold       <= w_hold_nxt;
      r_toa        <= w_toa_nxt;
      r_cycles     <= w_cycles_nxt;
      r_toa_valid  <= w_toa_valid_nxt;
      r_burst_done <= w_burst_done_nxt;
    end
  end

  assign bus.toa_valid    = r_toa_valid;
  assign bus.toa          = r_toa;
  assign bus.burst_done   = r_burst_done;
  assign bus.burst_cycles = r_cycles;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule
